// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and state encodings
// Used by both the transmitter and the receiver so their frame formats cannot drift apart.
package uart_pkg;

   localparam int TICKS_PER_BIT = 16;
   localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

   localparam logic [2:0] LAST_BIT_7 = 3'd6;
   localparam logic [2:0] LAST_BIT_8 = 3'd7;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   typedef struct packed {
      logic bit8;
      logic parity_en;
      logic odd_n_even;
   } frame_cfg_t;

   function automatic logic [2:0] last_bit_index(input logic bit8);
      return bit8 ? LAST_BIT_8 : LAST_BIT_7;
   endfunction

endpackage

// File: rtl/uart_tx_async.sv
// rtl/uart_tx_async.sv - UART transmitter: holding register / FIFO fetch plus frame FSM
// Serialises 7/8 data bits LSB first with optional parity and one stop bit, 16 baud ticks per bit.
module uart_tx_async #(
   parameter bit TX_FIFO = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       baud_clock,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       write_tx_byte,
   input  logic [7:0] tx_data,
   input  logic       fifo_empty,
   output logic       fifo_read,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx
);
   import uart_pkg::*;

   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic       fifo_read_q, fifo_read_d;

   tx_state_e  state_q, state_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       parity_q, parity_d;
   frame_cfg_t cfg_q, cfg_d;
   logic       tx_q, tx_d;

   logic       load_frame;

   // A pop is outstanding exactly while fifo_read_q is high; its data lands in hold on the next edge.
   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      fifo_read_d = 1'b0;
      if (TX_FIFO) begin
         if (fifo_read_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
         end else if (!hold_full_q && !fifo_empty) begin
            fifo_read_d = 1'b1;
         end
      end else if (write_tx_byte && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
      if (load_frame) begin
         hold_full_d = 1'b0;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      cfg_d      = cfg_q;
      tx_d       = tx_q;
      load_frame = 1'b0;

      if (baud_clock) begin
         if (state_q == TX_IDLE) begin
            load_frame = hold_full_q;
         end else begin
            tick_d = tick_q + 4'd1;
            if (tick_q == LAST_TICK) begin
               case (state_q)
                  TX_START: begin
                     state_d   = TX_DATA;
                     tx_d      = shift_q[0];
                     parity_d  = shift_q[0];
                     shift_d   = {1'b0, shift_q[7:1]};
                     bit_cnt_d = 3'd0;
                  end
                  TX_DATA: begin
                     if (bit_cnt_q == last_bit_index(cfg_q.bit8)) begin
                        if (cfg_q.parity_en) begin
                           state_d = TX_PARITY;
                           tx_d    = parity_q ^ cfg_q.odd_n_even;
                        end else begin
                           state_d = TX_STOP;
                           tx_d    = 1'b1;
                        end
                     end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        parity_d  = parity_q ^ shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                     end
                  end
                  TX_PARITY: begin
                     state_d = TX_STOP;
                     tx_d    = 1'b1;
                  end
                  TX_STOP: begin
                     // A byte already waiting goes straight into a new start bit, no idle gap.
                     if (hold_full_q) begin
                        load_frame = 1'b1;
                     end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                     end
                  end
                  default: begin
                     state_d = TX_IDLE;
                     tx_d    = 1'b1;
                  end
               endcase
            end
         end
      end

      if (load_frame) begin
         state_d   = TX_START;
         tick_d    = 4'd0;
         bit_cnt_d = 3'd0;
         shift_d   = hold_q;
         parity_d  = 1'b0;
         cfg_d     = '{bit8: bit8, parity_en: parity_en, odd_n_even: odd_n_even};
         tx_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         fifo_read_q <= 1'b0;
         state_q     <= TX_IDLE;
         tick_q      <= 4'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         parity_q    <= 1'b0;
         cfg_q       <= '0;
         tx_q        <= 1'b1;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         fifo_read_q <= fifo_read_d;
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         cfg_q       <= cfg_d;
         tx_q        <= tx_d;
      end
   end

   assign fifo_read = fifo_read_q;
   assign tx_ready  = ~hold_full_q;
   assign tx_busy   = (state_q != TX_IDLE);
   assign tx        = tx_q;

endmodule
